// File: rtl/mips_pkg.sv
// Opcode/funct encodings and control-bit bundle shared by the decode stage and the ALU.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use detector: a load still sitting in ID/EX whose destination is read by the
// instruction in ID.
module id_hazard_unit #(
  parameter int RADDR_W = 5
) (
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [RADDR_W-1:0] ex_dest,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  input  logic               rt_used,
  output logic               hazard
);

  assign hazard = ex_valid & ex_mem_read & (ex_dest != '0) &
                  ((ex_dest == rs) | (rt_used & (ex_dest == rt)));

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: decodes the fetched word into the ID/EX register, stalls on
// load-use, honours flush. Define ID_ILLEGAL_TRAP_EN to pass illegal encodings on as traps.
module id_decode_stage
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [XLEN-1:0]    if_instr,
  input  logic [XLEN-1:0]    if_pc,
  output logic [RADDR_W-1:0] rs_addr,
  output logic [RADDR_W-1:0] rt_addr,
  input  logic [XLEN-1:0]    rs_data,
  input  logic [XLEN-1:0]    rt_data,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [5:0]         ex_op_code,
  output logic [XLEN-1:0]    ex_in1,
  output logic [XLEN-1:0]    ex_in2,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [RADDR_W-1:0] ex_dest,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic [XLEN-1:0]    ex_br_target
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic               ex_illegal
`endif
);

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [XLEN-1:0]    imm_sext;
  logic [5:0]         dec_op;
  logic [XLEN-1:0]    dec_in2;
  logic [XLEN-1:0]    dec_store;
  logic [XLEN-1:0]    dec_target;
  logic [RADDR_W-1:0] dec_dest;
  ctrl_t              dec_ctrl;
  ctrl_t              ex_ctrl;
  logic               dec_legal;
  logic               rt_used;
  logic               load_use;
  logic               hazard;
  logic               load;
  logic               take;

  assign op         = if_instr[31:26];
  assign funct      = if_instr[5:0];
  assign rs_addr    = if_instr[25:21];
  assign rt_addr    = if_instr[20:16];
  assign imm_sext   = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
  assign dec_target = if_pc + XLEN'(4) + (imm_sext << 2);

  always_comb begin
    dec_op    = op;
    dec_in2   = imm_sext;
    dec_store = '0;
    dec_dest  = '0;
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    rt_used   = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_ADDU) begin
          dec_op             = OP_RTYPE;
          dec_in2            = rt_data;
          dec_dest           = if_instr[15:11];
          dec_ctrl.reg_write = 1'b1;
          rt_used            = 1'b1;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_ADDIU: begin
        dec_dest           = if_instr[20:16];
        dec_ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_dest           = if_instr[20:16];
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_store          = rt_data;
        dec_ctrl.mem_write = 1'b1;
        rt_used            = 1'b1;
      end
      OP_BEQ: begin
        dec_in2         = rt_data;
        dec_ctrl.branch = 1'b1;
        rt_used         = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    // $0 is hard-wired, so a write to it must never reach writeback
    if (dec_dest == '0) dec_ctrl.reg_write = 1'b0;
    if (!dec_legal) dec_ctrl = '0;
  end

  id_hazard_unit #(.RADDR_W(RADDR_W)) u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_dest     (ex_dest),
    .rs          (rs_addr),
    .rt          (rt_addr),
    .rt_used     (rt_used),
    .hazard      (load_use)
  );

  assign hazard   = load_use & if_valid;
  assign load     = ex_ready | ~ex_valid;
  // flush consumes whatever fetch presents, even with EX stalled
  assign if_ready = rst_n & ((load & ~hazard) | flush);
  assign take     = if_valid & if_ready & ~flush;

  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_branch    = ex_ctrl.branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_ctrl       <= '0;
      ex_op_code    <= '0;
      ex_in1        <= '0;
      ex_in2        <= '0;
      ex_store_data <= '0;
      ex_dest       <= '0;
      ex_br_target  <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
      ex_illegal    <= 1'b0;
`endif
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
      ex_illegal <= 1'b0;
`endif
    end else if (take) begin
`ifdef ID_ILLEGAL_TRAP_EN
      ex_valid <= 1'b1;
      if (!dec_legal) ex_illegal <= 1'b1;
`else
      ex_valid <= dec_legal;
`endif
      ex_ctrl       <= dec_ctrl;
      ex_op_code    <= dec_op;
      ex_in1        <= rs_data;
      ex_in2        <= dec_in2;
      ex_store_data <= dec_store;
      ex_dest       <= dec_dest;
      ex_br_target  <= dec_target;
    end else if (load) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Randomised and directed bench for id_decode_stage against an instruction-level model.
// Define ID_ILLEGAL_TRAP_EN to exercise the trap build.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [5:0]  ex_op_code;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic [31:0] ex_br_target;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  id_decode_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_op_code(ex_op_code), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_br_target(ex_br_target)
`ifdef ID_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        illegal;
    logic        legal;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] store;
    logic [31:0] target;
  } exp_t;

  exp_t m;
  logic exp_rdy;
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic rt_src(logic [31:0] instr);
    return (instr[31:26] == 6'b000000 && instr[5:0] == 6'b100001) ||
           instr[31:26] == 6'b101011 || instr[31:26] == 6'b000100;
  endfunction

  // What one instruction should turn into in ID/EX
  function automatic exp_t model_decode(logic [31:0] instr, logic [31:0] pc, logic [31:0] rsd, logic [31:0] rtd);
    exp_t e;
    logic [31:0] sx;
    e = '0;
    sx = {{16{instr[15]}}, instr[15:0]};
    e.legal = 1'b1;
    e.op = instr[31:26];
    e.in1 = rsd;
    e.in2 = sx;
    case (instr[31:26])
      6'b000000: if (instr[5:0] == 6'b100001) begin
                   e.op = 6'b000000; e.in2 = rtd; e.dest = instr[15:11]; e.rw = 1'b1;
                 end else e.legal = 1'b0;
      6'b001001: begin e.dest = instr[20:16]; e.rw = 1'b1; end
      6'b100011: begin e.dest = instr[20:16]; e.rw = 1'b1; e.mr = 1'b1; end
      6'b101011: begin e.store = rtd; e.mw = 1'b1; end
      6'b000100: begin e.in2 = rtd; e.br = 1'b1; e.target = pc + 32'd4 + sx * 32'd4; end
      default:   e.legal = 1'b0;
    endcase
    if (e.dest == 5'd0) e.rw = 1'b0;
    if (!e.legal) begin e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; end
`ifdef ID_ILLEGAL_TRAP_EN
    e.valid = 1'b1;
    e.illegal = m.illegal | ~e.legal;
`else
    e.valid = e.legal;
    e.illegal = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t obs_vec();
    exp_t o;
    o = '0;
    o.valid = ex_valid; o.rw = ex_reg_write; o.mr = ex_mem_read; o.mw = ex_mem_write;
    o.br = ex_branch; o.op = ex_op_code; o.dest = ex_dest; o.in1 = ex_in1; o.in2 = ex_in2;
    o.store = ex_store_data; o.target = ex_br_target;
`ifdef ID_ILLEGAL_TRAP_EN
    o.illegal = ex_illegal;
`endif
    return o;
  endfunction

  // Fields the model does not define for the current ID/EX content are don't-care
  function automatic exp_t mask_vec();
    exp_t k;
    k = '0;
    k.valid = 1'b1; k.rw = 1'b1; k.mr = 1'b1; k.mw = 1'b1; k.br = 1'b1; k.illegal = 1'b1;
    if (m.valid && m.legal) begin k.op = '1; k.in1 = '1; k.in2 = '1; end
    if (m.valid && (m.rw || m.mr)) k.dest = '1;
    if (m.valid && m.mw) k.store = '1;
    if (m.valid && m.br) k.target = '1;
    return k;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic fl, input logic exr);
    logic haz;
    @(negedge clk);
    if_valid = v; if_instr = instr; if_pc = pc; rs_data = rsd; rt_data = rtd;
    flush = fl; ex_ready = exr;
    haz = m.valid && m.mr && (m.dest != 5'd0) && v &&
          ((m.dest == instr[25:21]) || (rt_src(instr) && (m.dest == instr[20:16])));
    exp_rdy = rst_n && (fl || ((exr || !m.valid) && !haz));
    #1;
  endtask

  task automatic tick();
    exp_t d;
    d = model_decode(if_instr, if_pc, rs_data, rt_data);
    if (flush) begin
      m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.br = 1'b0; m.illegal = 1'b0;
    end else if (if_valid && exp_rdy) begin
      m = d;
    end else if (ex_ready || !m.valid) begin
      m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.br = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; ex_ready = 1'b1; m = '0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (if_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b want 0", if_ready); end
    nvec++; if (obs_vec() !== exp_t'(0)) begin nerr++; $display("FAIL reset_ex: got %h want 0", obs_vec()); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    nvec++; if (if_ready !== 1'b1) begin nerr++; $display("FAIL release_ready: got %b want 1", if_ready); end
    tick();
  endtask

  task automatic test_addiu();
    drive(1'b1, enc_i(6'b001001, 5'd1, 5'd2, 16'hFFFC), 32'h40, 32'd10, 32'h1234, 1'b0, 1'b1);
    nvec++; if (if_ready !== exp_rdy) begin nerr++; $display("FAIL addiu_ready: got %b want %b", if_ready, exp_rdy); end
    nvec++; if ({rs_addr, rt_addr} !== {5'd1, 5'd2}) begin nerr++; $display("FAIL addiu_regaddr: got %0d/%0d want 1/2", rs_addr, rt_addr); end
    tick();
    nvec++; if ((obs_vec() & mask_vec()) !== (m & mask_vec())) begin nerr++; $display("FAIL addiu_model: got %h want %h", obs_vec() & mask_vec(), m & mask_vec()); end
    nvec++;
    if ({ex_valid, ex_op_code, ex_in1, ex_in2, ex_dest, ex_reg_write} !== {1'b1, 6'b001001, 32'd10, 32'hFFFFFFFC, 5'd2, 1'b1}) begin
      nerr++; $display("FAIL addiu_fields: got v=%b op=%b in1=%h in2=%h dest=%0d rw=%b", ex_valid, ex_op_code, ex_in1, ex_in2, ex_dest, ex_reg_write);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ins [3];
    ins[0] = enc_i(6'b100011, 5'd1, 5'd3, 16'd8);
    ins[1] = enc_r(5'd3, 5'd5, 5'd4, 6'b100001);
    ins[2] = ins[1];
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 32'h200 + 32'(4 * i), $urandom, $urandom, 1'b0, 1'b1);
      nvec++; if (if_ready !== exp_rdy) begin nerr++; $display("FAIL loaduse_ready%0d: got %b want %b", i, if_ready, exp_rdy); end
      if (i == 1) begin
        nvec++; if (if_ready !== 1'b0) begin nerr++; $display("FAIL loaduse_stall: got %b want 0", if_ready); end
      end
      tick();
      nvec++; if ((obs_vec() & mask_vec()) !== (m & mask_vec())) begin nerr++; $display("FAIL loaduse_model%0d: got %h want %h", i, obs_vec() & mask_vec(), m & mask_vec()); end
      if (i == 1) begin
        nvec++; if (ex_valid !== 1'b0) begin nerr++; $display("FAIL loaduse_bubble: got %b want 0", ex_valid); end
      end
    end
    nvec++; if ({ex_valid, ex_op_code, ex_dest} !== {1'b1, 6'b000000, 5'd4}) begin nerr++; $display("FAIL loaduse_issue: got v=%b op=%b dest=%0d want 1/000000/4", ex_valid, ex_op_code, ex_dest); end
  endtask

  task automatic test_beq();
    logic [31:0] rtd;
    rtd = $urandom;
    drive(1'b1, enc_i(6'b000100, 5'd1, 5'd2, 16'hFFFF), 32'h100, $urandom, rtd, 1'b0, 1'b1);
    nvec++; if (if_ready !== exp_rdy) begin nerr++; $display("FAIL beq_ready: got %b want %b", if_ready, exp_rdy); end
    tick();
    nvec++; if ((obs_vec() & mask_vec()) !== (m & mask_vec())) begin nerr++; $display("FAIL beq_model: got %h want %h", obs_vec() & mask_vec(), m & mask_vec()); end
    nvec++; if ({ex_br_target, ex_branch, ex_in2} !== {32'h100, 1'b1, rtd}) begin nerr++; $display("FAIL beq_fields: got tgt=%h br=%b in2=%h want 100/1/%h", ex_br_target, ex_branch, ex_in2, rtd); end
  endtask

  task automatic test_ex_stall();
    exp_t held;
    drive(1'b1, enc_i(6'b001001, 5'd1, 5'd5, 16'd7), 32'h300, $urandom, $urandom, 1'b0, 1'b1);
    tick();
    held = obs_vec();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, enc_i(6'b001001, 5'd2, 5'd6, 16'd9), 32'h304, 32'h55, 32'h66, 1'b0, i == 3);
      nvec++; if (if_ready !== exp_rdy) begin nerr++; $display("FAIL exstall_ready%0d: got %b want %b", i, if_ready, exp_rdy); end
      tick();
      nvec++; if ((obs_vec() & mask_vec()) !== (m & mask_vec())) begin nerr++; $display("FAIL exstall_model%0d: got %h want %h", i, obs_vec() & mask_vec(), m & mask_vec()); end
      if (i < 3) begin
        nvec++; if (obs_vec() !== held) begin nerr++; $display("FAIL exstall_hold%0d: got %h want %h", i, obs_vec(), held); end
      end
    end
    nvec++; if ({ex_valid, ex_dest, ex_in1} !== {1'b1, 5'd6, 32'h55}) begin nerr++; $display("FAIL exstall_release: got v=%b dest=%0d in1=%h want 1/6/55", ex_valid, ex_dest, ex_in1); end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, enc_i(6'b100011, 5'd1, 5'd3, 16'd8), 32'h400, $urandom, $urandom, 1'b0, 1'b1);
    tick();
    drive(1'b1, enc_r(5'd3, 5'd5, 5'd4, 6'b100001), 32'h404, $urandom, $urandom, 1'b1, 1'b1);
    nvec++; if (if_ready !== 1'b1) begin nerr++; $display("FAIL flush_ready: got %b want 1", if_ready); end
    tick();
    nvec++; if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) begin nerr++; $display("FAIL flush_clear: got v=%b mr=%b rw=%b want 000", ex_valid, ex_mem_read, ex_reg_write); end
    drive(1'b1, enc_i(6'b001001, 5'd0, 5'd7, 16'd1), 32'h408, 32'h0, $urandom, 1'b0, 1'b1);
    nvec++; if (if_ready !== exp_rdy) begin nerr++; $display("FAIL flush_next_ready: got %b want %b", if_ready, exp_rdy); end
    tick();
    nvec++; if ((obs_vec() & mask_vec()) !== (m & mask_vec())) begin nerr++; $display("FAIL flush_next: got %h want %h", obs_vec() & mask_vec(), m & mask_vec()); end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [3];
    ins[0] = 32'hFC00_0000;
    ins[1] = enc_r(5'd1, 5'd2, 5'd3, 6'b100000);
    ins[2] = enc_i(6'b001001, 5'd1, 5'd0, 16'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 32'h500, $urandom, $urandom, 1'b0, 1'b1);
      tick();
      nvec++; if ((obs_vec() & mask_vec()) !== (m & mask_vec())) begin nerr++; $display("FAIL illegal_model%0d: got %h want %h", i, obs_vec() & mask_vec(), m & mask_vec()); end
    end
    nvec++; if ({ex_valid, ex_reg_write} !== 2'b10) begin nerr++; $display("FAIL addiu_r0: got v=%b rw=%b want 1/0", ex_valid, ex_reg_write); end
`ifdef ID_ILLEGAL_TRAP_EN
    nvec++; if (ex_illegal !== 1'b1) begin nerr++; $display("FAIL illegal_sticky: got %b want 1", ex_illegal); end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    nvec++; if (ex_illegal !== 1'b0) begin nerr++; $display("FAIL illegal_flush: got %b want 0", ex_illegal); end
`else
    drive(1'b1, ins[0], 32'h504, $urandom, $urandom, 1'b0, 1'b1);
    tick();
    nvec++; if (ex_valid !== 1'b0) begin nerr++; $display("FAIL illegal_bubble: got %b want 0", ex_valid); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, enc_i(6'b100011, 5'd1, 5'd9, 16'd4), 32'h600, $urandom, $urandom, 1'b0, 1'b1);
    tick();
    drive(1'b1, enc_i(6'b101011, 5'd2, 5'd9, 16'd0), 32'h604, $urandom, $urandom, 1'b0, 1'b1);
    nvec++; if (if_ready !== 1'b0) begin nerr++; $display("FAIL midrst_stall: got %b want 0", if_ready); end
    #1;
    rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0;
    m = '0;
    #1;
    nvec++; if ({if_ready, obs_vec()} !== {1'b0, exp_t'(0)}) begin nerr++; $display("FAIL midrst_state: got rdy=%b ex=%h want 0", if_ready, obs_vec()); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  ops [5];
    ops[0] = 6'b001001; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100; ops[4] = 6'b111111;
    for (int i = 0; i < 400; i++) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0:       instr = enc_r(rs, rt, rd, 6'b100001);
        1:       instr = enc_r(rs, rt, rd, 6'($urandom_range(0, 63)));
        default: instr = enc_i(ops[$urandom_range(0, 4)], rs, rt, 16'($urandom));
      endcase
      drive($urandom_range(0, 9) != 0, instr, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      nvec++; if (if_ready !== exp_rdy) begin nerr++; $display("FAIL rand_ready%0d: got %b want %b", i, if_ready, exp_rdy); end
      tick();
      nvec++; if ((obs_vec() & mask_vec()) !== (m & mask_vec())) begin nerr++; $display("FAIL rand_ex%0d: got %h want %h", i, obs_vec() & mask_vec(), m & mask_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_load_use();
    test_beq();
    test_ex_stall();
    test_flush_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
